// File: rtl/ap_ctrl_hs_driver_if.sv
// Kernel-side ap_ctrl_hs pins. The driver owns start/continue; the kernel
// answers with ready/done.
interface ap_ctrl_hs_driver_if;
    logic ap_start;
    logic ap_continue;
    logic ap_ready;
    logic ap_done;

    modport master (output ap_start, output ap_continue, input ap_ready, input ap_done);
    modport slave  (input ap_start, input ap_continue, output ap_ready, output ap_done);
endinterface

// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs initiator: launches a kernel N times, tracks issued/completed
// runs, latency/interval statistics, watchdog timeout and protocol errors.
module ap_ctrl_hs_driver #(
    parameter int RUN_W       = 16,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cmd_start,
    input  logic [RUN_W-1:0] cmd_runs,
    input  logic             cmd_abort,
    output logic             busy,
    output logic             done,
    output logic [2:0]       err,
    ap_ctrl_hs_driver_if.master kern,
    output logic [RUN_W-1:0] issued_cnt,
    output logic [RUN_W-1:0] done_cnt,
    output logic [CNT_W-1:0] total_cycles,
    output logic [CNT_W-1:0] first_latency,
    output logic [CNT_W-1:0] max_interval
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic TMO_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYC);

    state_t           r_state, w_state_nxt;
    logic [RUN_W-1:0] r_n, r_issued, r_dcnt;
    logic [CNT_W-1:0] r_total, r_first, r_max, r_ival, r_prog;
    logic [2:0]       r_err;
    logic             r_done;

    logic             w_start, w_active, w_accept, w_hs, w_cnt_done, w_spur, w_tmo, w_fin;
    logic [RUN_W-1:0] w_issued_nxt, w_dcnt_nxt;
    logic [CNT_W-1:0] w_prog_nxt, w_ival_cand;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // start is a decode of registered state only, so reset drops it at once
    assign w_start  = (r_state == S_RUN) && (r_issued < r_n);
    assign w_active = (r_state != S_IDLE);
    assign w_accept = (r_state == S_IDLE) && cmd_start;

    // Per-cycle event decode: handshake, counted done, spurious done, watchdog
    always_comb begin
        w_hs         = w_start & kern.ap_ready;
        w_issued_nxt = r_issued + RUN_W'(w_hs);
        // a done in the same cycle as its own handshake is legitimate
        w_cnt_done   = w_active && kern.ap_done && (r_dcnt != w_issued_nxt);
        w_spur       = w_active && kern.ap_done && (r_dcnt == w_issued_nxt);
        w_dcnt_nxt   = r_dcnt + RUN_W'(w_cnt_done);
        w_prog_nxt   = (w_hs || w_cnt_done) ? '0 : sat_inc(r_prog);
        w_tmo        = TMO_EN && w_active && (w_prog_nxt >= TMO_LIM);
        w_ival_cand  = sat_inc(r_ival);
    end

    // Next-state and command-finish decode
    always_comb begin
        w_state_nxt = r_state;
        w_fin       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_start) begin
                    if (cmd_runs == '0) w_fin = 1'b1;
                    else                w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_tmo || (w_dcnt_nxt == r_n)) begin
                    w_state_nxt = S_IDLE;
                    w_fin       = 1'b1;
                end else if (cmd_abort) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_tmo || (w_dcnt_nxt == r_issued)) begin
                    w_state_nxt = S_IDLE;
                    w_fin       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Counters, statistics and sticky errors; all hold while idle
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_n <= '0; r_issued <= '0; r_dcnt <= '0;
            r_total <= '0; r_first <= '0; r_max <= '0; r_ival <= '0; r_prog <= '0;
            r_err <= '0; r_done <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_accept) begin
                r_n      <= cmd_runs;
                r_issued <= '0;
                r_dcnt   <= '0;
                // the first RUN cycle already reads as cycle 1
                r_total  <= (cmd_runs != '0) ? CNT_W'(1) : '0;
                r_first  <= '0;
                r_max    <= '0;
                r_ival   <= '0;
                r_prog   <= '0;
                r_err    <= '0;
            end else if (w_active) begin
                r_issued <= w_issued_nxt;
                r_dcnt   <= w_dcnt_nxt;
                r_prog   <= w_prog_nxt;
                if (w_state_nxt != S_IDLE) r_total <= sat_inc(r_total);
                if (w_cnt_done) begin
                    r_ival <= '0;
                    if (r_dcnt == '0)              r_first <= r_total;
                    else if (w_ival_cand > r_max)  r_max   <= w_ival_cand;
                end else begin
                    r_ival <= w_ival_cand;
                end
                r_err[0] <= r_err[0] | w_tmo;
                r_err[1] <= r_err[1] | w_spur;
                r_err[2] <= r_err[2] | ((r_state == S_RUN) && (w_state_nxt == S_DRAIN));
            end
        end
    end

    assign kern.ap_start    = w_start;
    assign kern.ap_continue = 1'b1;
    assign busy             = w_active;
    assign done             = r_done;
    assign err              = r_err;
    assign issued_cnt       = r_issued;
    assign done_cnt         = r_dcnt;
    assign total_cycles     = r_total;
    assign first_latency    = r_first;
    assign max_interval     = r_max;
endmodule
